// File: rtl/pipelined_shifter_if.sv
// Valid/ready operation and result bus for the operand-2 barrel shifter.
// The producer drives in_* and out_ready; the shifter drives in_ready and out_*.
interface pipelined_shifter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_mode;
    logic [CNT_W-1:0] in_count;
    logic             in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_count, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_count, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined LSL/LSR/ASR/ROR/RRX barrel shifter with ARM carry-out and full backpressure.
// Every shift is reduced to a right rotation, then masked/sign-filled in the last stage.
module pipelined_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_shifter_if.slave   bus
);
    localparam int unsigned LW    = $clog2(WIDTH);
    localparam int unsigned CMP_W = (CNT_W > LW + 1) ? CNT_W : LW + 1;
    localparam logic [CMP_W-1:0] W_C = CMP_W'(WIDTH);

    typedef enum logic [2:0] {
        OP_FIX = 3'd0,
        OP_LSL = 3'd1,
        OP_LSR = 3'd2,
        OP_ASR = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] data;
        logic [LW-1:0]    rot;
        logic [LW-1:0]    sh;
        logic             sign;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t             prep_c;
    stage_t             s_d [LATENCY];
    stage_t             s_q [LATENCY];
    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] adv_c;
    logic [CMP_W-1:0]   n_ext;
    logic [LW-1:0]      r_c;

    // Classify the op: out-of-range and trivial cases resolve here as OP_FIX.
    always_comb begin
        n_ext         = CMP_W'(bus.in_count);
        r_c           = n_ext[LW-1:0];
        prep_c        = '0;
        prep_c.op     = OP_FIX;
        prep_c.data   = bus.in_data;
        prep_c.carry  = bus.in_carry;
        prep_c.tag    = bus.in_tag;
        prep_c.sign   = bus.in_data[WIDTH-1];
        case (bus.in_mode)
            3'b000: begin
                if (n_ext == '0) begin
                end else if (n_ext < W_C) begin
                    prep_c.op  = OP_LSL;
                    prep_c.rot = LW'(W_C - n_ext);
                    prep_c.sh  = LW'(n_ext);
                end else begin
                    prep_c.data  = '0;
                    prep_c.carry = (n_ext == W_C) ? bus.in_data[0] : 1'b0;
                end
            end
            3'b001: begin
                if (n_ext == '0) begin
                end else if (n_ext < W_C) begin
                    prep_c.op  = OP_LSR;
                    prep_c.rot = LW'(n_ext);
                    prep_c.sh  = LW'(n_ext);
                end else begin
                    prep_c.data  = '0;
                    prep_c.carry = (n_ext == W_C) ? bus.in_data[WIDTH-1] : 1'b0;
                end
            end
            3'b010: begin
                if (n_ext == '0) begin
                end else if (n_ext < W_C) begin
                    prep_c.op  = OP_ASR;
                    prep_c.rot = LW'(n_ext);
                    prep_c.sh  = LW'(n_ext);
                end else begin
                    prep_c.data  = {WIDTH{bus.in_data[WIDTH-1]}};
                    prep_c.carry = bus.in_data[WIDTH-1];
                end
            end
            3'b011: begin
                if (r_c != '0) begin
                    prep_c.op  = OP_ROR;
                    prep_c.rot = r_c;
                end else if (n_ext != '0) begin
                    prep_c.carry = bus.in_data[WIDTH-1];
                end
            end
            3'b100: begin
                prep_c.data  = {bus.in_carry, bus.in_data[WIDTH-1:1]};
                prep_c.carry = bus.in_data[0];
            end
            default: begin
            end
        endcase
    end

    // Stage k applies its share of the rotate levels; the last stage also masks and picks carry.
    function automatic stage_t stage_fn(input stage_t s, input int unsigned k);
        stage_t           o;
        logic [WIDTH-1:0] keep;
        int unsigned      lo;
        int unsigned      hi;
        o  = s;
        lo = (k * LW) / LATENCY;
        hi = ((k + 1) * LW) / LATENCY;
        for (int unsigned j = 0; j < LW; j++) begin
            if (j >= lo && j < hi && o.rot[j]) begin
                o.data = (o.data >> (1 << j)) | (o.data << (WIDTH - (1 << j)));
            end
        end
        if (k == LATENCY - 1) begin
            keep = (o.op == OP_LSL) ? ({WIDTH{1'b1}} << o.sh) : ({WIDTH{1'b1}} >> o.sh);
            case (o.op)
                OP_LSL: begin
                    o.carry = o.data[0];
                    o.data  = o.data & keep;
                end
                OP_LSR: begin
                    o.carry = o.data[WIDTH-1];
                    o.data  = o.data & keep;
                end
                OP_ASR: begin
                    o.carry = o.data[WIDTH-1];
                    o.data  = (o.data & keep) | ({WIDTH{o.sign}} & ~keep);
                end
                OP_ROR:  o.carry = o.data[WIDTH-1];
                default: begin
                end
            endcase
        end
        return o;
    endfunction

    always_comb begin
        s_d[0] = stage_fn(prep_c, 0);
        for (int unsigned k = 1; k < LATENCY; k++) begin
            s_d[k] = stage_fn(s_q[k-1], k);
        end
    end

    // A stage may advance if the consumer is ready or any stage at or after it is empty.
    always_comb begin
        logic hole;
        hole  = 1'b0;
        adv_c = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            hole     = hole | ~v_q[k];
            adv_c[k] = bus.out_ready | hole;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                s_q[k] <= '0;
            end
        end else begin
            if (adv_c[0]) begin
                v_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    s_q[0] <= s_d[0];
                end
            end
            for (int unsigned k = 1; k < LATENCY; k++) begin
                if (adv_c[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        s_q[k] <= s_d[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = adv_c[0];
    assign bus.out_valid = v_q[LATENCY-1];
    assign bus.out_data  = s_q[LATENCY-1].data;
    assign bus.out_carry = s_q[LATENCY-1].carry;
    assign bus.out_tag   = s_q[LATENCY-1].tag;
endmodule
